// File: rtl/kcpsm_event_fifo_port.sv
// Purpose: KCPSM3/PacoBlaze I/O-port peripheral that buffers producer events in a FIFO and raises an interrupt.
// Latency: in_port is registered one cycle after port_id; push/pop/flush take effect on the next clk edge.
// Backpressure: none toward the producer; a push into a full FIFO is dropped and sets a sticky overflow flag.
// Optional: define EVFIFO_WATERMARK_EN to enable a firmware-programmable interrupt watermark on WMARK_PORT.
module kcpsm_event_fifo_port #(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] DATA_PORT   = 8'h01,
    parameter logic [7:0] STATUS_PORT = 8'h02,
    parameter logic [7:0] CTRL_PORT   = 8'h03,
    parameter logic [7:0] WMARK_PORT  = 8'h04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] event_data,
    input  logic       event_valid
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic          r_overflow;
    logic          r_int_en;
    logic          r_interrupt;
    logic [7:0]    r_in_port;
    logic [4:0]    w_wmark;

    logic       w_full, w_empty, w_ctrl_wr, w_wmark_wr, w_flush;
    logic       w_pop_req, w_pop, w_push, w_drop, w_int_set, w_int_en_rise;
    logic [4:0] w_count_nxt;
    logic       w_unused_ok;

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == 5'd0);
    assign w_ctrl_wr  = write_strobe && (port_id == CTRL_PORT);
    assign w_wmark_wr = write_strobe && (port_id == WMARK_PORT);
    assign w_flush    = w_ctrl_wr && out_port[0];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a coincident push.
    assign w_pop_req  = read_strobe && (port_id == DATA_PORT) && !w_empty;
    assign w_pop      = w_pop_req && !w_flush;
    assign w_push     = event_valid && (!w_full || w_pop_req) && !w_flush;
    assign w_drop     = event_valid && w_full && !w_pop_req;

    assign w_int_en_rise = w_ctrl_wr && out_port[2] && !r_int_en;
    assign w_int_set     = (w_push && r_int_en && (w_count_nxt >= w_wmark))
                         || (w_int_en_rise && (w_count_nxt >= w_wmark));

    // Upper control bits are don't-care; in the default build the watermark port decode is unused.
    assign w_unused_ok = ^{out_port[7:3], w_wmark_wr};

    // Occupancy after this cycle's flush/push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_flush)
            w_count_nxt = 5'd0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + 5'd1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 5'd1;
    end

    // FIFO storage write at the tail.
    always_ff @(posedge clk) begin
        if (!reset && w_push)
            r_mem[r_wr_ptr] <= event_data;
    end

    // Pointers, count, sticky overflow and interrupt enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_overflow <= 1'b0;
            r_int_en   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A dropped push wins over a same-cycle overflow clear.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (w_ctrl_wr && out_port[1])
                r_overflow <= 1'b0;
            if (w_ctrl_wr)
                r_int_en <= out_port[2];
        end
    end

`ifdef EVFIFO_WATERMARK_EN
    logic [4:0] r_wmark;
    // Programmable watermark: 0 means 1, anything above DEPTH saturates.
    always_ff @(posedge clk) begin
        if (reset)
            r_wmark <= 5'd1;
        else if (w_wmark_wr) begin
            if (out_port[4:0] == 5'd0)
                r_wmark <= 5'd1;
            else if (out_port[4:0] > DEPTH_C)
                r_wmark <= DEPTH_C;
            else
                r_wmark <= out_port[4:0];
        end
    end
    assign w_wmark = r_wmark;
`else
    assign w_wmark = 5'd1;
`endif

    // Interrupt request: acknowledge beats a new set; disabling int_en leaves it pending.
    always_ff @(posedge clk) begin
        if (reset)
            r_interrupt <= 1'b0;
        else if (interrupt_ack)
            r_interrupt <= 1'b0;
        else if (w_int_set)
            r_interrupt <= 1'b1;
    end

    // Registered read mux; unmapped ports return zero so peripherals can be OR-combined.
    always_ff @(posedge clk) begin
        if (reset)
            r_in_port <= 8'h00;
        else if (port_id == DATA_PORT)
            r_in_port <= w_empty ? 8'h00 : r_mem[r_rd_ptr];
        else if (port_id == STATUS_PORT)
            r_in_port <= {r_count, r_overflow, w_full, w_empty};
        else
            r_in_port <= 8'h00;
    end

    assign in_port   = r_in_port;
    assign interrupt = r_interrupt;
endmodule

// File: tb/tb_kcpsm_event_fifo_port.sv
// Purpose: directed self-checking bench for kcpsm_event_fifo_port (DEPTH=16).
// Latency: reads follow the processor's two-cycle port_id / read_strobe sequence.
// Backpressure: not applicable; overflow and full-FIFO cases are driven explicitly.
module tb_kcpsm_event_fifo_port;
    localparam logic [7:0] DATA_P   = 8'h01;
    localparam logic [7:0] STATUS_P = 8'h02;
    localparam logic [7:0] CTRL_P   = 8'h03;
    localparam logic [7:0] WMARK_P  = 8'h04;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;
    logic [7:0] event_data = 8'h00;
    logic       event_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rv;

    kcpsm_event_fifo_port #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
        .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack),
        .event_data(event_data), .event_valid(event_valid)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] v);
        port_id = p; out_port = v; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        port_id = p; read_strobe = 1'b0;
        tick();
        read_strobe = 1'b1;
        v = in_port;
        tick();
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        event_data = d; event_valid = 1'b1;
        tick();
        event_valid = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    initial begin
        #1;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_port", in_port, 8'h00);
        check("rst_irq", {7'b0, interrupt}, 8'h00);
        rd(STATUS_P, rv); check("rst_status", rv, 8'h01);
        rd(8'h7F, rv);    check("unmapped", rv, 8'h00);
        check("rst_irq2", {7'b0, interrupt}, 8'h00);

        // Enable interrupts, push three events.
        wr(CTRL_P, 8'h04);
        check("en_empty_irq", {7'b0, interrupt}, 8'h00);
        push(8'h31);
        check("irq_after_push", {7'b0, interrupt}, 8'h01);
        push(8'h32);
        push(8'h33);
        ack();
        check("irq_after_ack", {7'b0, interrupt}, 8'h00);
        rd(DATA_P, rv); check("data0", rv, 8'h31);
        rd(DATA_P, rv); check("data1", rv, 8'h32);
        rd(DATA_P, rv); check("data2", rv, 8'h33);
        rd(STATUS_P, rv); check("status_drained", rv, 8'h01);
        check("no_reassert", {7'b0, interrupt}, 8'h00);

        // Enabling with a non-empty FIFO raises the interrupt.
        wr(CTRL_P, 8'h00);
        push(8'h77);
        check("disabled_push_irq", {7'b0, interrupt}, 8'h00);
        wr(CTRL_P, 8'h04);
        check("en_rise_irq", {7'b0, interrupt}, 8'h01);
        // A push coincident with ack does not re-raise.
        interrupt_ack = 1'b1; event_data = 8'h78; event_valid = 1'b1;
        tick();
        interrupt_ack = 1'b0; event_valid = 1'b0;
        check("ack_beats_push", {7'b0, interrupt}, 8'h00);
        push(8'h79);
        check("push_sets_again", {7'b0, interrupt}, 8'h01);
        // Disabling int_en leaves the pending interrupt; flush in the same write.
        wr(CTRL_P, 8'h01);
        check("disable_keeps_irq", {7'b0, interrupt}, 8'h01);
        rd(STATUS_P, rv); check("flush_status", rv, 8'h01);
        ack();

        // Overflow and recovery.
        for (int i = 0; i < 17; i++) push(8'(i));
        rd(STATUS_P, rv); check("ovf_status", rv, 8'h86);
        wr(CTRL_P, 8'h02);
        rd(STATUS_P, rv); check("ovf_clear", rv, 8'h82);
        wr(CTRL_P, 8'h01);
        rd(STATUS_P, rv); check("ovf_flush", rv, 8'h01);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
        rd(STATUS_P, rv); check("full_status", rv, 8'h82);
        port_id = DATA_P;
        tick();
        read_strobe = 1'b1; event_data = 8'hAA; event_valid = 1'b1;
        rv = in_port;
        tick();
        read_strobe = 1'b0; event_valid = 1'b0; port_id = 8'h00;
        check("simul_pop", rv, 8'h40);
        rd(STATUS_P, rv); check("simul_status", rv, 8'h82);
        for (int i = 1; i < 16; i++) begin
            rd(DATA_P, rv); check("drain", rv, 8'h40 + 8'(i));
        end
        rd(DATA_P, rv); check("drain_last", rv, 8'hAA);
        rd(STATUS_P, rv); check("drain_status", rv, 8'h01);

        // Empty read has no effect.
        rd(DATA_P, rv); check("empty_data", rv, 8'h00);
        rd(STATUS_P, rv); check("empty_status", rv, 8'h01);
        push(8'h55);
        rd(DATA_P, rv); check("after_empty", rv, 8'h55);

        // Reset mid-operation discards contents and pending interrupt.
        wr(CTRL_P, 8'h04);
        push(8'h66);
        check("pre_reset_irq", {7'b0, interrupt}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_irq", {7'b0, interrupt}, 8'h00);
        rd(STATUS_P, rv); check("mid_reset_status", rv, 8'h01);

`ifdef EVFIFO_WATERMARK_EN
        wr(WMARK_P, 8'h04);
        wr(CTRL_P, 8'h04);
        push(8'hA1); check("wm_push1", {7'b0, interrupt}, 8'h00);
        push(8'hA2); check("wm_push2", {7'b0, interrupt}, 8'h00);
        push(8'hA3); check("wm_push3", {7'b0, interrupt}, 8'h00);
        push(8'hA4); check("wm_push4", {7'b0, interrupt}, 8'h01);
        ack();
        wr(CTRL_P, 8'h01);
        wr(WMARK_P, 8'h00);
        wr(CTRL_P, 8'h04);
        check("wm0_idle", {7'b0, interrupt}, 8'h00);
        push(8'hB1); check("wm0_push1", {7'b0, interrupt}, 8'h01);
`else
        wr(WMARK_P, 8'h04);
        wr(CTRL_P, 8'h05);
        push(8'hC1); check("nowm_push1", {7'b0, interrupt}, 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
